// File: rtl/dft_probe_collector.sv
// DFT status-probe collector: enables probe cells, captures tdi, shifts out on tdo.
// Optional DFT_PROBE_PARITY_EN appends an even-parity bit after the data word.
module dft_probe_collector #(
  parameter int NPROBE = 16,
  parameter int SETTLE = 4,
  parameter logic [NPROBE-1:0] MASK_DEF = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NPROBE-1:0] chan_mask,
  output logic [NPROBE-1:0] ten,
  input  logic [NPROBE-1:0] tdi,
  output logic              tdo,
  output logic              tdo_valid,
  output logic              busy,
  output logic              done,
  input  logic              CELG,
  input  logic              CELSUB,
  input  logic              CELV
);

`ifdef DFT_PROBE_PARITY_EN
  localparam int SW = NPROBE + 1;
`else
  localparam int SW = NPROBE;
`endif
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [NPROBE-1:0] sync1, sync2;
  logic [NPROBE-1:0] mask_q, word;
  logic [SW-1:0]     sr, sr_load;
  logic [7:0]        scnt;
  logic [CW-1:0]     bcnt;
  logic              unused_rails;

  assign unused_rails = ^{CELG, CELSUB, CELV};

  assign word = sync2 & mask_q;

`ifdef DFT_PROBE_PARITY_EN
  assign sr_load = {^word, word};
`else
  assign sr_load = word;
`endif

  // tdi is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= tdi;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (start) state_n = S_ENABLE;
      S_ENABLE:  if (scnt == '0) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_SHIFT;
      S_SHIFT:   if (bcnt == '0) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= MASK_DEF;
      scnt   <= '0;
      bcnt   <= '0;
      sr     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mask_q <= chan_mask;
            scnt   <= 8'(SETTLE - 1);
          end
        end
        S_ENABLE: begin
          if (scnt != '0) scnt <= scnt - 1'b1;
        end
        S_CAPTURE: begin
          sr   <= sr_load;
          bcnt <= CW'(SW - 1);
        end
        S_SHIFT: begin
          sr <= sr >> 1;
          if (bcnt != '0) bcnt <= bcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // outputs decode registered state only, so reset clears them at once
  always_comb begin
    ten       = '0;
    tdo       = 1'b0;
    tdo_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (1'b1)
      (state == S_ENABLE),
      (state == S_CAPTURE): ten = mask_q;
      (state == S_SHIFT): begin
        ten       = mask_q;
        tdo       = sr[0];
        tdo_valid = 1'b1;
      end
      (state == S_DONE): done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dft_probe_collector.sv
// Bench for dft_probe_collector: timing model per cycle plus directed runs.
// Honours DFT_PROBE_PARITY_EN to match the build under test.
module tb_dft_probe_collector;

  localparam int NP = 16;
  localparam int ST = 4;
`ifdef DFT_PROBE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = NP + PAR;
  localparam int L  = ST + NB + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NP-1:0] chan_mask = '0;
  logic [NP-1:0] tdi = '0;
  logic [NP-1:0] ten;
  logic          tdo, tdo_valid, busy, done;
  logic          celg = 1'b0;
  logic          celsub = 1'b0;
  logic          celv = 1'b1;

  dft_probe_collector #(.NPROBE(NP), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .chan_mask(chan_mask), .ten(ten), .tdi(tdi),
    .tdo(tdo), .tdo_valid(tdo_valid), .busy(busy),
    .done(done), .CELG(celg), .CELSUB(celsub), .CELV(celv)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // model: a run is just "k cycles since accepted start"
  bit            m_act = 1'b0;
  int            m_k = 0;
  logic [NP-1:0] m_mask = '0;
  logic [NP-1:0] m_word = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (m_act) begin
      if (m_k == ST + 1) m_word = tdi & m_mask;
      m_k++;
      if (m_k > L) m_act = 1'b0;
    end else if (start) begin
      m_act  = 1'b1;
      m_k    = 1;
      m_mask = chan_mask;
    end
  end

  function automatic logic ebit(int i);
    if (i < NP) return m_word[i];
    return ^m_word;
  endfunction

  always @(negedge clk) begin
    logic [NP-1:0] e_ten;
    logic e_tdo, e_v, e_b, e_d;
    e_ten = '0;
    e_tdo = 1'b0;
    e_v   = 1'b0;
    e_b   = 1'b0;
    e_d   = 1'b0;
    if (rst_n && m_act) begin
      e_b = 1'b1;
      e_d = (m_k == L);
      if (m_k <= L - 1) e_ten = m_mask;
      if (m_k >= ST + 2 && m_k <= ST + 1 + NB) begin
        e_v   = 1'b1;
        e_tdo = ebit(m_k - ST - 2);
      end
    end
    checks++;
    if ({ten, tdo, tdo_valid, busy, done} !== {e_ten, e_tdo, e_v, e_b, e_d}) begin
      errors++;
      $display("FAIL cycle%0d got ten=%h tdo=%b v=%b busy=%b done=%b want ten=%h tdo=%b v=%b busy=%b done=%b",
               cyc, ten, tdo, tdo_valid, busy, done, e_ten, e_tdo, e_v, e_b, e_d);
    end
  end

  // serial word collector
  logic [NB-1:0] cur = '0;
  logic [NB-1:0] last_word = '0;
  int nb = 0, last_nb = 0, done_cnt = 0, first_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur = '0;
      nb  = 0;
    end else begin
      if (tdo_valid) begin
        if (nb == 0) first_cyc = cyc;
        if (nb < NB) cur[nb] = tdo;
        nb++;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        last_word = cur;
        last_nb   = nb;
        cur       = '0;
        nb        = 0;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic go(logic [NP-1:0] m, logic [NP-1:0] t, output int s);
    chan_mask = m;
    tdi       = t;
    start     = 1'b1;
    s         = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(int n0);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != n0) break;
      @(negedge clk);
      #1;
    end
    if (done_cnt == n0) begin
      errors++;
      $display("FAIL wait_done timeout got=0 want=1");
    end
    tick(1);
  endtask

  initial begin
    int s, s2, n0;
    tick(2);
    chk("reset_out", {ten, tdo, tdo_valid, busy, done}, '0);
    rst_n = 1'b1;
    tick(2);

    // basic capture
    n0 = done_cnt;
    go(16'hFFFF, 16'hA5C3, s);
    wait_done(n0);
    chk("basic_word", last_word[NP-1:0], 16'hA5C3);
    chk("basic_nbits", last_nb, NB);
    chk("first_lat", first_cyc - s, 6);
    chk("done_lat", done_cyc - s, 22 + PAR);

    // masking
    n0 = done_cnt;
    go(16'h00FF, 16'hFFFF, s);
    tick(1);
    chk("mask_ten", ten, 16'h00FF);
    wait_done(n0);
    chk("mask_word", last_word[NP-1:0], 16'h00FF);

    // ignored starts, then back-to-back
    n0 = done_cnt;
    go(16'hFFFF, 16'h5A0F, s);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(L - 4);
    chk("busy_mid", busy, 1'b1);
    start = 1'b1;
    chk("done_at_L", done, 1'b1);
    tick(1);
    chk("one_done", done_cnt, n0 + 1);
    chk("ign_word", last_word[NP-1:0], 16'h5A0F);
    s2 = cyc;
    n0 = done_cnt;
    tick(1);
    start = 1'b0;
    wait_done(n0);
    chk("b2b_word", last_word[NP-1:0], 16'h5A0F);
    chk("b2b_lat", done_cyc - s2, L);

    // reset during shift
    go(16'hFFFF, 16'hC001, s);
    tick(9);
    chk("v5_valid", tdo_valid, 1'b1);
    n0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {ten, tdo, tdo_valid, busy, done}, '0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_nodone", done_cnt, n0);
    go(16'hFFFF, 16'h8421, s);
    wait_done(n0);
    chk("post_rst_word", last_word[NP-1:0], 16'h8421);

    // tdi changes after capture
    n0 = done_cnt;
    go(16'hFFFF, 16'h0001, s);
    tick(5);
    tdi = 16'hFFFF;
    wait_done(n0);
    chk("frozen_word", last_word[NP-1:0], 16'h0001);

    // all channels masked
    n0 = done_cnt;
    go(16'h0000, 16'hFFFF, s);
    tick(2);
    chk("zero_ten", ten, 16'h0000);
    wait_done(n0);
    chk("zero_word", last_word[NP-1:0], 16'h0000);
    chk("zero_nbits", last_nb, NB);

`ifdef DFT_PROBE_PARITY_EN
    n0 = done_cnt;
    go(16'hFFFF, 16'h0007, s);
    wait_done(n0);
    chk("par7_nbits", last_nb, 17);
    chk("par7_bit", last_word[NB-1], 1'b1);
    n0 = done_cnt;
    go(16'hFFFF, 16'h0003, s);
    wait_done(n0);
    chk("par3_bit", last_word[NB-1], 1'b0);
    chk("par3_done", done_cyc - s, 23);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
